dma_priority_arbiter: RTL and testbench

- Channel request/priority stage of the 8237A-5 DMA controller.
- Consumes the programmed Command, Request and Mask registers plus the external DREQ pins.
- Resolves one serviced channel, runs the HRQ/HLDA bus-hold handshake with the CPU, and drives DACK.
- Feeds the active channel number to the timing/address-counter logic and takes back its end-of-service indication.

---
 rtl/dma_priority_arbiter_pkg.sv | 37 +++
 rtl/dma_priority_arbiter_if.sv | 29 ++
 rtl/dma_priority_arbiter_encoder.sv | 37 +++
 rtl/dma_priority_arbiter.sv | 94 +++++++++
 tb/tb_dma_priority_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dma_priority_arbiter_pkg.sv
// Shared DMA types for the 8237A-style channel request/priority stage.
// Register layouts match the programmed Command and Request registers bit for bit.
package dma_priority_arbiter_pkg;

  localparam int NumChannels = 4;
  localparam int ChWidth     = $clog2(NumChannels);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GRANT
  } ArbState;

  typedef bit [NumChannels-1:0] MaskRegister;

  // Bit 7 down to bit 0 of the Command register.
  typedef struct packed {
    logic DACKsense;
    logic DREQsense;
    logic ExtWrite;
    logic FRpriority;
    logic CompTiming;
    logic ContrDis;
    logic Ch0AddrHold;
    logic MemToMem;
  } CommandRegister;

  typedef struct packed {
    logic               set;
    logic [ChWidth-1:0] ChNum;
  } RequestRegister;

  function automatic logic [NumChannels-1:0] ch_onehot(input logic [ChWidth-1:0] ch);
    return NumChannels'(1) << ch;
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Register-block, DREQ/DACK and CPU hold-handshake signals of the arbiter.
// The master side drives the programmed registers and pins; the slave side is the arbiter.
interface dma_priority_arbiter_if;
  import dma_priority_arbiter_pkg::*;

  logic [NumChannels-1:0] DREQ;
  CommandRegister         CmdReg;
  MaskRegister            MaskReg;
  logic                   ReqWr;
  RequestRegister         ReqWord;
  logic                   HLDA;
  logic                   SvcDone;
  logic                   TC;
  logic                   HRQ;
  logic [NumChannels-1:0] DACK;
  logic [ChWidth-1:0]     ActiveCh;
  logic                   ChValid;
  logic [NumChannels-1:0] SwReq;

  modport master (
    output DREQ, CmdReg, MaskReg, ReqWr, ReqWord, HLDA, SvcDone, TC,
    input  HRQ, DACK, ActiveCh, ChValid, SwReq
  );

  modport slave (
    input  DREQ, CmdReg, MaskReg, ReqWr, ReqWord, HLDA, SvcDone, TC,
    output HRQ, DACK, ActiveCh, ChValid, SwReq
  );
endinterface

// File: rtl/dma_priority_arbiter_encoder.sv
// Combinational winner selection: fixed (channel 0 first) or rotating from ptr.
// The request vector is rotated so that a plain lowest-index search serves both modes.
module dma_priority_encoder
  import dma_priority_arbiter_pkg::*;
(
  input  logic [NumChannels-1:0] req,
  input  logic [ChWidth-1:0]     ptr,
  input  logic                   rotate,
  output logic [ChWidth-1:0]     winner,
  output logic                   any_valid
);

  logic [ChWidth-1:0]     base;
  logic [NumChannels-1:0] rot_req;
  logic [ChWidth-1:0]     offset;

  assign base = rotate ? ptr : '0;

  generate
    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_rot
      logic [ChWidth-1:0] idx;
      assign idx         = ChWidth'(gi) + base;
      assign rot_req[gi] = req[idx];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (rot_req[i]) offset = ChWidth'(i);
    end
  end

  assign winner    = offset + base;
  assign any_valid = |req;

endmodule

// File: rtl/dma_priority_arbiter.sv
// 8237A channel arbiter: request normalisation, software request register,
// priority pointer and the IDLE/REQ/GRANT hold-request handshake.
module dma_priority_arbiter
  import dma_priority_arbiter_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  dma_priority_arbiter_if.slave arb
);

  ArbState                state_reg, state_next;
  logic [NumChannels-1:0] req_q_reg;
  logic [NumChannels-1:0] sw_req_reg, sw_req_next;
  logic [ChWidth-1:0]     ptr_reg, ptr_next;
  logic [ChWidth-1:0]     active_reg, active_next;
  logic [NumChannels-1:0] hw_req, eff_req, elig_req, dack_active;
  logic [ChWidth-1:0]     winner;
  logic                   any_valid;

  assign hw_req  = arb.CmdReg.DREQsense ? ~arb.DREQ : arb.DREQ;
  assign eff_req = (hw_req & ~arb.MaskReg) | sw_req_reg;

  // Memory-to-memory transfers are only ever kicked off by channel 0.
  assign elig_req = arb.CmdReg.MemToMem ? (req_q_reg & NumChannels'(1)) : req_q_reg;

  dma_priority_encoder u_encoder (
    .req       (elig_req),
    .ptr       (ptr_reg),
    .rotate    (arb.CmdReg.FRpriority),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // The write is applied after the TC clear so it wins on the same channel.
  always_comb begin
    sw_req_next = sw_req_reg;
    if (arb.SvcDone && arb.TC) sw_req_next[active_reg] = 1'b0;
    if (arb.ReqWr) sw_req_next[arb.ReqWord.ChNum] = arb.ReqWord.set;
  end

  always_comb begin
    state_next  = state_reg;
    active_next = active_reg;
    ptr_next    = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (any_valid && !arb.CmdReg.ContrDis) state_next = REQ;
      end
      REQ: begin
        if (!any_valid || arb.CmdReg.ContrDis) begin
          state_next = IDLE;
        end else if (arb.HLDA) begin
          state_next  = GRANT;
          active_next = winner;
        end
      end
      GRANT: begin
        if (arb.SvcDone) begin
          state_next = IDLE;
          if (arb.CmdReg.FRpriority) ptr_next = active_reg + ChWidth'(1);
        end else if (!arb.HLDA) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= IDLE;
      req_q_reg  <= '0;
      sw_req_reg <= '0;
      ptr_reg    <= '0;
      active_reg <= '0;
    end else begin
      state_reg  <= state_next;
      req_q_reg  <= eff_req;
      sw_req_reg <= sw_req_next;
      ptr_reg    <= ptr_next;
      active_reg <= active_next;
    end
  end

  // A pending request is withheld while the controller is disabled; a live grant is not.
  assign arb.HRQ      = (state_reg == GRANT) || ((state_reg == REQ) && !arb.CmdReg.ContrDis);
  assign arb.ChValid  = (state_reg == GRANT);
  assign arb.ActiveCh = active_reg;
  assign arb.SwReq    = sw_req_reg;

  assign dack_active = (state_reg == GRANT) ? ch_onehot(active_reg) : '0;
  assign arb.DACK    = arb.CmdReg.DACKsense ? dack_active : ~dack_active;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: fixed/rotating priority, mask and software
// requests, withdrawal, HLDA abort, controller disable, mem-to-mem, reset mid-grant, polarity.
module tb_dma_priority_arbiter;
  import dma_priority_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dma_priority_arbiter_if ifc ();

  dma_priority_arbiter dut (
    .CLK   (clk),
    .RESET (rst),
    .arb   (ifc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst          = 1'b1;
    ifc.DREQ     = '0;
    ifc.CmdReg   = '0;
    ifc.MaskReg  = '0;
    ifc.ReqWr    = 1'b0;
    ifc.ReqWord  = '0;
    ifc.HLDA     = 1'b0;
    ifc.SvcDone  = 1'b0;
    ifc.TC       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for HRQ, holds off `delay` cycles, raises HLDA and checks the grant.
  task automatic do_grant(input string tag, input int ch, input logic [3:0] dack, input int delay);
    int n = 0;
    while (ifc.HRQ !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    repeat (delay) tick();
    check({tag, "_hrq"}, 32'(ifc.HRQ), 32'd1);
    ifc.HLDA = 1'b1;
    tick();
    check({tag, "_chvalid"}, 32'(ifc.ChValid), 32'd1);
    check({tag, "_activech"}, 32'(ifc.ActiveCh), 32'(ch));
    check({tag, "_dack"}, 32'(ifc.DACK), 32'(dack));
  endtask

  task automatic finish_svc(input string tag, input logic tc);
    ifc.SvcDone = 1'b1;
    ifc.TC      = tc;
    tick();
    ifc.SvcDone = 1'b0;
    ifc.TC      = 1'b0;
    ifc.HLDA    = 1'b0;
    check({tag, "_hrq"}, 32'(ifc.HRQ), 32'd0);
    check({tag, "_chvalid"}, 32'(ifc.ChValid), 32'd0);
    check({tag, "_dack"}, 32'(ifc.DACK), ifc.CmdReg.DACKsense ? 32'h0 : 32'hf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rot_dack [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int         rot_ch   [5] = '{0, 1, 2, 3, 0};

    // Reset state and fixed priority with HLDA three cycles after HRQ.
    reset_dut();
    check("rst_hrq", 32'(ifc.HRQ), 32'd0);
    check("rst_dack", 32'(ifc.DACK), 32'hf);
    check("rst_chvalid", 32'(ifc.ChValid), 32'd0);
    check("rst_activech", 32'(ifc.ActiveCh), 32'd0);
    check("rst_swreq", 32'(ifc.SwReq), 32'd0);
    ifc.DREQ = 4'b1010;
    tick();
    check("fix_hrq_lat1", 32'(ifc.HRQ), 32'd0);
    tick();
    check("fix_hrq_lat2", 32'(ifc.HRQ), 32'd1);
    do_grant("fix_ch1", 1, 4'b1101, 3);
    ifc.DREQ = 4'b1000;
    finish_svc("fix_svc1", 1'b0);
    do_grant("fix_ch3", 3, 4'b0111, 0);
    ifc.DREQ = 4'b0000;
    finish_svc("fix_svc3", 1'b0);

    // Rotating priority with all channels requesting.
    reset_dut();
    ifc.CmdReg.FRpriority = 1'b1;
    ifc.DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_grant($sformatf("rot%0d", i), rot_ch[i], rot_dack[i], 0);
      finish_svc($sformatf("rot%0d_svc", i), 1'b0);
    end

    // Masked hardware requests, software request on channel 2.
    reset_dut();
    ifc.MaskReg = 4'b1111;
    ifc.DREQ    = 4'b1111;
    repeat (3) tick();
    check("mask_no_hrq", 32'(ifc.HRQ), 32'd0);
    ifc.ReqWr   = 1'b1;
    ifc.ReqWord = 3'b110;
    tick();
    ifc.ReqWr = 1'b0;
    check("sw_set", 32'(ifc.SwReq), 32'b0100);
    do_grant("sw_ch2a", 2, 4'b1011, 0);
    finish_svc("sw_notc", 1'b0);
    check("sw_kept", 32'(ifc.SwReq), 32'b0100);
    do_grant("sw_ch2b", 2, 4'b1011, 0);
    ifc.ReqWr   = 1'b1;
    ifc.ReqWord = 3'b110;
    finish_svc("sw_wrwin", 1'b1);
    ifc.ReqWr = 1'b0;
    check("sw_write_wins", 32'(ifc.SwReq), 32'b0100);
    do_grant("sw_ch2c", 2, 4'b1011, 0);
    finish_svc("sw_tc", 1'b1);
    check("sw_cleared", 32'(ifc.SwReq), 32'b0000);
    repeat (3) tick();
    check("sw_idle_hrq", 32'(ifc.HRQ), 32'd0);

    // Request withdrawn before HLDA.
    reset_dut();
    ifc.DREQ = 4'b0001;
    tick();
    check("wd_hrq1", 32'(ifc.HRQ), 32'd0);
    tick();
    check("wd_hrq2", 32'(ifc.HRQ), 32'd1);
    ifc.DREQ = 4'b0000;
    tick();
    check("wd_hrq3", 32'(ifc.HRQ), 32'd1);
    check("wd_dack3", 32'(ifc.DACK), 32'hf);
    tick();
    check("wd_hrq4", 32'(ifc.HRQ), 32'd0);
    check("wd_dack4", 32'(ifc.DACK), 32'hf);

    // HLDA abort in rotating mode: ptr sits at 1 and must stay there.
    reset_dut();
    ifc.CmdReg.FRpriority = 1'b1;
    ifc.DREQ = 4'b0001;
    do_grant("ab_ch0", 0, 4'b1110, 0);
    ifc.DREQ = 4'b0011;
    finish_svc("ab_svc0", 1'b0);
    do_grant("ab_ch1a", 1, 4'b1101, 0);
    ifc.HLDA = 1'b0;
    tick();
    check("ab_dack", 32'(ifc.DACK), 32'hf);
    check("ab_chvalid", 32'(ifc.ChValid), 32'd0);
    do_grant("ab_ch1b", 1, 4'b1101, 0);
    ifc.DREQ = 4'b0000;
    finish_svc("ab_svc1", 1'b0);

    // Controller disable blocks new grants but lets a live grant finish.
    reset_dut();
    ifc.CmdReg.ContrDis = 1'b1;
    ifc.DREQ = 4'b0001;
    repeat (4) tick();
    check("cd_no_hrq", 32'(ifc.HRQ), 32'd0);
    ifc.CmdReg.ContrDis = 1'b0;
    tick();
    check("cd_release_hrq", 32'(ifc.HRQ), 32'd1);
    do_grant("cd_ch0", 0, 4'b1110, 0);
    ifc.CmdReg.ContrDis = 1'b1;
    tick();
    check("cd_grant_holds", 32'(ifc.ChValid), 32'd1);
    ifc.DREQ = 4'b0000;
    finish_svc("cd_svc", 1'b0);

    // Memory-to-memory: only a channel 0 request starts a transfer.
    reset_dut();
    ifc.CmdReg.MemToMem = 1'b1;
    ifc.DREQ = 4'b0110;
    repeat (4) tick();
    check("m2m_no_hrq", 32'(ifc.HRQ), 32'd0);
    ifc.ReqWr   = 1'b1;
    ifc.ReqWord = 3'b100;
    tick();
    ifc.ReqWr = 1'b0;
    do_grant("m2m_ch0", 0, 4'b1110, 0);
    finish_svc("m2m_svc", 1'b1);
    check("m2m_swreq", 32'(ifc.SwReq), 32'd0);

    // Reset during GRANT, then inverted DREQ and DACK polarity.
    reset_dut();
    ifc.DREQ = 4'b0100;
    do_grant("rg_ch2", 2, 4'b1011, 0);
    rst = 1'b1;
    tick();
    check("rg_hrq", 32'(ifc.HRQ), 32'd0);
    check("rg_dack", 32'(ifc.DACK), 32'hf);
    check("rg_chvalid", 32'(ifc.ChValid), 32'd0);
    check("rg_activech", 32'(ifc.ActiveCh), 32'd0);
    rst      = 1'b0;
    ifc.HLDA = 1'b0;
    ifc.CmdReg.DREQsense = 1'b1;
    ifc.DREQ = 4'b1110;
    do_grant("pol_ch0", 0, 4'b1110, 0);
    ifc.CmdReg.DACKsense = 1'b1;
    #1;
    check("pol_dack_high", 32'(ifc.DACK), 32'b0001);
    ifc.DREQ = 4'b1111;
    finish_svc("pol_svc", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
